// File: rtl/piggy_report_rx_pkg.sv
// piggy_pkg: shared constants, state types and the coin-total helper for the
// piggy-bank report receiver (UART byte receiver + frame parser).
package piggy_pkg;

    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam int FRAME_LEN  = 14;
    localparam int NUM_FIELDS = 4;
    localparam int AMT_W      = 8;
    localparam int ACC_W      = 10;
    localparam int TOTAL_W    = 13;

    localparam int W10 = 10;
    localparam int W5  = 5;
    localparam int W2  = 2;
    localparam int W1  = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_e;
    typedef enum logic {PARSE, RESYNC} parse_state_e;

    // Weighted sum of the four coin counts; max 255*18 = 4590 fits in 13 bits.
    function automatic logic [TOTAL_W-1:0] coin_total(
        input logic [AMT_W-1:0] a10,
        input logic [AMT_W-1:0] a5,
        input logic [AMT_W-1:0] a2,
        input logic [AMT_W-1:0] a1
    );
        return TOTAL_W'(a10) * TOTAL_W'(W10)
             + TOTAL_W'(a5)  * TOTAL_W'(W5)
             + TOTAL_W'(a2)  * TOTAL_W'(W2)
             + TOTAL_W'(a1)  * TOTAL_W'(W1);
    endfunction

endpackage

// File: rtl/piggy_report_rx_if.sv
// piggy_report_rx_if: serial input plus decoded report outputs.
//   master : receiver side (consumes i_Rx_Serial, drives the report)
//   slave  : line driver / report consumer side
interface piggy_report_rx_if;
    logic                          i_Rx_Serial;
    logic [7:0]                    o_amount10;
    logic [7:0]                    o_amount5;
    logic [7:0]                    o_amount2;
    logic [7:0]                    o_amount1;
    logic [piggy_pkg::TOTAL_W-1:0] o_total;
    logic                          o_frame_valid;
    logic                          o_frame_error;
    logic                          o_rx_byte_valid;
    logic [7:0]                    o_rx_byte;

    modport master (
        input  i_Rx_Serial,
        output o_amount10, o_amount5, o_amount2, o_amount1, o_total,
        output o_frame_valid, o_frame_error, o_rx_byte_valid, o_rx_byte
    );

    modport slave (
        output i_Rx_Serial,
        input  o_amount10, o_amount5, o_amount2, o_amount1, o_total,
        input  o_frame_valid, o_frame_error, o_rx_byte_valid, o_rx_byte
    );
endinterface

// File: rtl/piggy_report_rx_uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with 2-flop line synchroniser.
// Ports: clk, reset (sync, active-high), rx_serial (raw line),
//        rx_byte / rx_byte_valid (registered byte + one-cycle strobe),
//        framing_error (one-cycle strobe when the stop bit samples low).
//
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits at bit centres, LSB first
// STOP  | sampling the stop bit, then straight back to IDLE
module uart_rx_byte
    import piggy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       framing_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q, sync2_q;
    bit_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Down-counter reloads on every phase change; sampling happens at zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = START;
                    cnt_d   = HALF_TC;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (sync2_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = FULL_TC;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_TC;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            byte_q    <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx_serial;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_byte       = byte_q;
    assign rx_byte_valid = valid_q;
    assign framing_error = ferr_q;

endmodule

// File: rtl/piggy_report_rx.sv
// piggy_report_rx: receives the piggy-bank serial report, parses the 14-byte
// frame "d10 d5 d2 d1 CR LF" (3 ASCII digits per field) and presents the last
// valid coin counts and their baht total.
// Ports: clk, reset (sync, active-high), bus (piggy_report_rx_if.master):
//        i_Rx_Serial in; amounts, o_total, frame/byte strobes and o_rx_byte out.
//
// state  | meaning
// PARSE  | accepting frame bytes at index 0..13
// RESYNC | frame already flagged bad, dropping bytes until LF
module piggy_report_rx
    import piggy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FRAME_DIGITS = 3
) (
    input logic               clk,
    input logic               reset,
    piggy_report_rx_if.master bus
);
    localparam logic [3:0] CR_IDX = 4'(NUM_FIELDS * FRAME_DIGITS);
    localparam logic [3:0] LF_IDX = 4'(FRAME_LEN - 1);

    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx_byte (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (bus.i_Rx_Serial),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .framing_error(rx_ferr)
    );

    parse_state_e         pstate_q, pstate_d;
    logic [3:0]           idx_q, idx_d;
    logic [ACC_W-1:0]     acc_q [NUM_FIELDS];
    logic [ACC_W-1:0]     acc_d [NUM_FIELDS];
    logic [AMT_W-1:0]     amt_q [NUM_FIELDS];
    logic [AMT_W-1:0]     amt_d [NUM_FIELDS];
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic                 fv_q, fv_d;
    logic                 fe_q, fe_d;

    logic [1:0]           fld, pos;
    logic                 is_digit;
    logic [3:0]           digit;
    logic [ACC_W-1:0]     acc_base, acc_new;

    assign fld      = 2'(idx_q / 4'(FRAME_DIGITS));
    assign pos      = 2'(idx_q % 4'(FRAME_DIGITS));
    assign is_digit = (rx_byte >= CHAR_0) && (rx_byte <= CHAR_9);
    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign digit    = rx_byte[3:0];
    // First digit of a field restarts its accumulator.
    assign acc_base = (pos == 2'd0) ? '0 : acc_q[fld];
    assign acc_new  = acc_base * ACC_W'(10) + ACC_W'(digit);

    always_comb begin
        pstate_d = pstate_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        amt_d    = amt_q;
        total_d  = total_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        if (pstate_q == PARSE) begin
            if (rx_ferr) begin
                fe_d     = 1'b1;
                pstate_d = RESYNC;
            end else if (rx_byte_valid) begin
                if (rx_byte == CHAR_LF) begin
                    // An early LF is already a frame boundary: no RESYNC needed.
                    idx_d = 4'd0;
                    if (idx_q == LF_IDX) begin
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            amt_d[i] = acc_q[i][AMT_W-1:0];
                        end
                        total_d = coin_total(acc_q[0][AMT_W-1:0], acc_q[1][AMT_W-1:0],
                                             acc_q[2][AMT_W-1:0], acc_q[3][AMT_W-1:0]);
                        fv_d    = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else if (idx_q < CR_IDX) begin
                    if (!is_digit ||
                        ((pos == 2'(FRAME_DIGITS - 1)) && (acc_new > ACC_W'(255)))) begin
                        fe_d     = 1'b1;
                        pstate_d = RESYNC;
                    end else begin
                        acc_d[fld] = acc_new;
                        idx_d      = idx_q + 4'd1;
                    end
                end else if ((idx_q == CR_IDX) && (rx_byte == CHAR_CR)) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    fe_d     = 1'b1;
                    pstate_d = RESYNC;
                end
            end
        end else begin
            if (rx_byte_valid && (rx_byte == CHAR_LF)) begin
                pstate_d = PARSE;
                idx_d    = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q <= PARSE;
            idx_q    <= 4'd0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                acc_q[i] <= '0;
                amt_q[i] <= '0;
            end
            total_q  <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            pstate_q <= pstate_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            total_q  <= total_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    assign bus.o_amount10      = amt_q[0];
    assign bus.o_amount5       = amt_q[1];
    assign bus.o_amount2       = amt_q[2];
    assign bus.o_amount1       = amt_q[3];
    assign bus.o_total         = total_q;
    assign bus.o_frame_valid   = fv_q;
    assign bus.o_frame_error   = fe_q;
    assign bus.o_rx_byte_valid = rx_byte_valid;
    assign bus.o_rx_byte       = rx_byte;

endmodule

// File: tb/tb_piggy_report_rx.sv
// Self-checking bench for piggy_report_rx at CLKS_PER_BIT = 16.
module tb_piggy_report_rx;
    localparam int CPB = 16;

    logic clk;
    logic reset;

    piggy_report_rx_if bus ();

    piggy_report_rx #(
        .CLKS_PER_BIT(CPB),
        .FRAME_DIGITS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [111:0] frame;
        logic         exp_valid;
        logic         exp_err;
        logic [7:0]   a10, a5, a2, a1;
        logic [12:0]  total;
    } vec_t;

    vec_t vecs [9];

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitors: only this process writes these.
    int tot_v = 0, tot_e = 0, tot_b = 0;
    int lat_bad = 0, chg_bad = 0;
    logic       prev_bv = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_rst = 1'b1;
    logic [44:0] prev_out = '0;

    always @(negedge clk) begin
        if (bus.o_frame_valid) tot_v++;
        if (bus.o_frame_error) tot_e++;
        if (bus.o_rx_byte_valid) tot_b++;
        if (bus.o_frame_valid && !(prev_bv && prev_byte == 8'h0A)) lat_bad++;
        if (!reset && !prev_rst && !bus.o_frame_valid &&
            ({bus.o_amount10, bus.o_amount5, bus.o_amount2, bus.o_amount1, bus.o_total} != prev_out))
            chg_bad++;
        prev_bv   = bus.o_rx_byte_valid;
        prev_byte = bus.o_rx_byte;
        prev_rst  = reset;
        prev_out  = {bus.o_amount10, bus.o_amount5, bus.o_amount2, bus.o_amount1, bus.o_total};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.i_Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.i_Rx_Serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.i_Rx_Serial = stop;
        repeat (CPB) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
    endtask

    task automatic send_bytes(input logic [111:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(f[8*(13-i) +: 8], 1'b1);
    endtask

    task automatic chk_out(input string tag, input int a10, input int a5, input int a2,
                           input int a1, input int total);
        chk({tag, " a10"}, int'(bus.o_amount10), a10);
        chk({tag, " a5"}, int'(bus.o_amount5), a5);
        chk({tag, " a2"}, int'(bus.o_amount2), a2);
        chk({tag, " a1"}, int'(bus.o_amount1), a1);
        chk({tag, " total"}, int'(bus.o_total), total);
    endtask

    logic [111:0] fr;
    int sv, se, sb;

    initial begin
        vecs[0] = '{"012007003045\r\n", 1'b1, 1'b0, 8'd12, 8'd7, 8'd3, 8'd45, 13'd206};
        vecs[1] = '{"01A007003045\r\n", 1'b0, 1'b1, 8'd12, 8'd7, 8'd3, 8'd45, 13'd206};
        vecs[2] = '{"012007003045\r\n", 1'b1, 1'b0, 8'd12, 8'd7, 8'd3, 8'd45, 13'd206};
        vecs[3] = '{"300000000000\r\n", 1'b0, 1'b1, 8'd12, 8'd7, 8'd3, 8'd45, 13'd206};
        vecs[4] = '{"255255255255\r\n", 1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 13'd4590};
        vecs[5] = '{"256000000000\r\n", 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 13'd4590};
        vecs[6] = '{"003002001009X\n", 1'b0, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 13'd4590};
        vecs[7] = '{"003002001009\r\n", 1'b1, 1'b0, 8'd3, 8'd2, 8'd1, 8'd9, 13'd51};
        vecs[8] = '{"000000000000\r\n", 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 13'd0};

        bus.i_Rx_Serial = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk_out("reset", 0, 0, 0, 0, 0);
        chk("reset pulses", int'({bus.o_frame_valid, bus.o_frame_error, bus.o_rx_byte_valid}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 9; v++) begin
            sv = tot_v; se = tot_e; sb = tot_b;
            send_bytes(vecs[v].frame, 0, 13);
            repeat (4) @(negedge clk);
            chk($sformatf("vec%0d valid", v), tot_v - sv, int'(vecs[v].exp_valid));
            chk($sformatf("vec%0d error", v), tot_e - se, int'(vecs[v].exp_err));
            chk($sformatf("vec%0d bytes", v), tot_b - sb, 14);
            chk($sformatf("vec%0d last byte", v), int'(bus.o_rx_byte), 8'h0A);
            chk_out($sformatf("vec%0d", v), int'(vecs[v].a10), int'(vecs[v].a5),
                    int'(vecs[v].a2), int'(vecs[v].a1), int'(vecs[v].total));
        end

        // Framing error at index 5, rest of that frame, then a valid frame
        sv = tot_v; se = tot_e; sb = tot_b;
        fr = "000000000000\r\n";
        send_bytes(fr, 0, 4);
        send_byte(8'h30, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send_bytes(fr, 6, 13);
        fr = "000000000001\r\n";
        send_bytes(fr, 0, 13);
        repeat (4) @(negedge clk);
        chk("ferr error", tot_e - se, 1);
        chk("ferr valid", tot_v - sv, 1);
        chk("ferr bytes", tot_b - sb, 27);
        chk_out("ferr", 0, 0, 0, 1, 1);

        // Short low glitch on the line
        sb = tot_b; se = tot_e;
        bus.i_Rx_Serial = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch bytes", tot_b - sb, 0);
        chk("glitch error", tot_e - se, 0);

        // Early LF at index 4, then a full frame
        sv = tot_v; se = tot_e;
        fr = "0120\n000000000";
        send_bytes(fr, 0, 4);
        fr = "003002001009\r\n";
        send_bytes(fr, 0, 13);
        repeat (4) @(negedge clk);
        chk("early lf error", tot_e - se, 1);
        chk("early lf valid", tot_v - sv, 1);
        chk_out("early lf", 3, 2, 1, 9, 51);

        // Back-to-back frames, no idle gap
        sv = tot_v; se = tot_e;
        fr = "012007003045\r\n";
        send_bytes(fr, 0, 13);
        fr = "255000000001\r\n";
        send_bytes(fr, 0, 13);
        repeat (4) @(negedge clk);
        chk("b2b valid", tot_v - sv, 2);
        chk("b2b error", tot_e - se, 0);
        chk_out("b2b", 255, 0, 0, 1, 2551);

        // Reset during byte 7
        fr = "001002003004\r\n";
        send_bytes(fr, 0, 6);
        bus.i_Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.i_Rx_Serial = fr[8*6 + i];
            repeat (CPB) @(negedge clk);
        end
        sv = tot_v; se = tot_e; sb = tot_b;
        reset = 1'b1;
        bus.i_Rx_Serial = 1'b1;
        repeat (2) @(negedge clk);
        chk_out("in reset", 0, 0, 0, 0, 0);
        chk("in reset byte", int'(bus.o_rx_byte), 0);
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("post reset pulses", (tot_v - sv) + (tot_e - se) + (tot_b - sb), 0);
        chk_out("post reset", 0, 0, 0, 0, 0);
        sv = tot_v; se = tot_e;
        send_bytes(fr, 0, 13);
        repeat (4) @(negedge clk);
        chk("after reset valid", tot_v - sv, 1);
        chk("after reset error", tot_e - se, 0);
        chk_out("after reset", 1, 2, 3, 4, 30);

        chk("valid latency", lat_bad, 0);
        chk("outputs held", chg_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
